// File: rtl/quadrature_rotary_tx_if.sv
// Command channel for quadrature_rotary_tx.
//
// Handshake: a command transfers on the rising clock edge where
// cmd_valid and cmd_ready are both high. The master holds cmd_dir and
// cmd_steps stable while cmd_valid is high. The slave raises cmd_ready
// only when it is idle. After the transfer edge the slave has latched
// everything it needs, so the master may change the fields freely.
//
// Signals:
//   cmd_valid  master->slave  command request
//   cmd_ready  slave->master  slave can accept a command
//   cmd_dir    master->slave  1 = right (clockwise), 0 = left
//   cmd_steps  master->slave  detent count, unsigned
interface quadrature_rotary_tx_if #(
   parameter int STEP_W = 8
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_dir;
   logic [STEP_W-1:0] cmd_steps;

   modport master (output cmd_valid, output cmd_dir, output cmd_steps, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_dir, input cmd_steps, output cmd_ready);
endinterface

// File: rtl/quadrature_rotary_tx.sv
// Rotary-encoder emulator. It turns step commands into two-phase quadrature
// signals ROT_A/ROT_B. One detent is one full Gray cycle starting and
// ending at rest (00). Each quadrature state is held for PHASE_CYCLES
// clocks. Consecutive detents of a command are separated by GAP_CYCLES
// clocks at rest.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   cmd        command channel (slave side of quadrature_rotary_tx_if)
//   ROT_A      quadrature phase A, registered
//   ROT_B      quadrature phase B, registered
//   busy       command in progress (inverse of cmd_ready)
//   done       one-cycle pulse when a command completes
//   position   signed running detent count, wraps modulo 2^POS_W
//   state_dbg  current FSM state (IDLE=0, PHASE=1, GAP=2)
module quadrature_rotary_tx #(
   parameter int PHASE_CYCLES = 1000,
   parameter int GAP_CYCLES   = 5000,
   parameter int STEP_W       = 8,
   parameter int POS_W        = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   quadrature_rotary_tx_if.slave cmd,
   output logic                  ROT_A,
   output logic                  ROT_B,
   output logic                  busy,
   output logic                  done,
   output logic [POS_W-1:0]      position,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PHASE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // One timer serves both the phase hold and the gap, so it is sized for the longer of the two.
   localparam int TMAX  = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
   localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TMR_W-1:0] PHASE_LAST = TMR_W'(PHASE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;

   state_t             state;
   logic [TMR_W-1:0]   timer;
   logic [1:0]         phase_idx;
   logic [STEP_W-1:0]  steps_left;
   logic               dir_q;
   logic               ready_q;
   // done is raised one cycle after the FSM settles in IDLE.
   // done_pending carries the completion across that cycle.
   logic               done_pending;

   // Quadrature state after the transition numbered phase_idx (0..3) of a detent.
   // Right: 00->10->11->01->00. Left: 00->01->11->10->00.
   function automatic logic [1:0] next_ab(input logic dir, input logic [1:0] idx);
      logic [1:0] ab;
      case (idx)
         2'd0:    ab = dir ? 2'b10 : 2'b01;
         2'd1:    ab = 2'b11;
         2'd2:    ab = dir ? 2'b01 : 2'b10;
         default: ab = 2'b00;
      endcase
      return ab;
   endfunction

   assign cmd.cmd_ready = ready_q;
   assign busy          = ~ready_q;
   assign state_dbg     = state;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= S_IDLE;
         timer        <= '0;
         phase_idx    <= '0;
         steps_left   <= '0;
         dir_q        <= 1'b0;
         ready_q      <= 1'b1;
         done_pending <= 1'b0;
         done         <= 1'b0;
         ROT_A        <= 1'b0;
         ROT_B        <= 1'b0;
         position     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (done_pending) begin
                  done         <= 1'b1;
                  done_pending <= 1'b0;
                  ready_q      <= 1'b1;
               end
               // Acceptance needs ready_q. That flop is still low in the cycle
               // right after a command ends, so a new command can be accepted
               // no earlier than the cycle in which done is high.
               if (cmd.cmd_valid && ready_q) begin
                  dir_q      <= cmd.cmd_dir;
                  steps_left <= cmd.cmd_steps;
                  timer      <= '0;
                  phase_idx  <= '0;
                  if (cmd.cmd_steps == '0) begin
                     done_pending <= 1'b1;
                  end else begin
                     state   <= S_PHASE;
                     ready_q <= 1'b0;
                  end
               end
            end

            S_PHASE: begin
               if (timer == PHASE_LAST) begin
                  timer     <= '0;
                  {ROT_A, ROT_B} <= next_ab(dir_q, phase_idx);
                  phase_idx <= phase_idx + 2'd1;
                  // The fourth transition returns the outputs to rest and completes the detent.
                  if (phase_idx == 2'd3) begin
                     position   <= dir_q ? position + POS_W'(1) : position - POS_W'(1);
                     steps_left <= steps_left - STEP_W'(1);
                     if (steps_left == STEP_W'(1)) begin
                        state        <= S_IDLE;
                        done_pending <= 1'b1;
                     end else if (GAP_CYCLES > 0) begin
                        state <= S_GAP;
                     end
                     // If there is no gap, stay in PHASE. The next detent then
                     // starts with the timer already cleared.
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            S_GAP: begin
               if (timer == GAP_LAST) begin
                  timer <= '0;
                  state <= S_PHASE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_quadrature_rotary_tx.sv
module tb_quadrature_rotary_tx;

   localparam int P      = 4;
   localparam int G      = 2;
   localparam int STEP_W = 8;
   localparam int POS_W  = 16;
   localparam int L      = 4 * P + G;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic             ROT_A, ROT_B, busy, done;
   logic [POS_W-1:0] position;
   logic [1:0]       state_dbg;

   quadrature_rotary_tx_if #(.STEP_W(STEP_W)) cmd_bus ();

   quadrature_rotary_tx #(
      .PHASE_CYCLES (P),
      .GAP_CYCLES   (G),
      .STEP_W       (STEP_W),
      .POS_W        (POS_W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cmd       (cmd_bus),
      .ROT_A     (ROT_A),
      .ROT_B     (ROT_B),
      .busy      (busy),
      .done      (done),
      .position  (position),
      .state_dbg (state_dbg)
   );

   int vectors     = 0;
   int miscompares = 0;
   int exp_pos     = 0;

   // ---------------- reference model ----------------
   // Expected {A,B} k clocks after the accept edge. Detent d begins at d*L.
   // Its transitions fall at P, 2P, 3P and 4P clocks into the detent.
   function automatic logic [1:0] model_ab(input logic dir, input int n, input int k);
      int d, j;
      if (k <= 0) return 2'b00;
      d = k / L;
      if (d >= n) return 2'b00;
      j = (k % L) / P;
      case (j)
         1:       return dir ? 2'b10 : 2'b01;
         2:       return 2'b11;
         3:       return dir ? 2'b01 : 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   // Number of detents completed k clocks after the accept edge.
   function automatic int model_detents(input int n, input int k);
      int c;
      if (k < 4 * P) return 0;
      c = (k - 4 * P) / L + 1;
      return (c > n) ? n : c;
   endfunction

   // ---------------- loopback rotary decoder ----------------
   // Its order position is 00=0, 10=1, 11=2, 01=3 (increasing = right).
   // A detent is reported when the outputs return to rest after four steps in one direction.
   logic [1:0] dec_prev;
   int         dec_sub;
   logic [0:0] dec_q[$];
   logic [0:0] exp_q[$];

   function automatic int ord(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   always @(negedge CLK) begin
      if (RST) begin
         dec_prev = 2'b00;
         dec_sub  = 0;
      end else if ({ROT_A, ROT_B} != dec_prev) begin
         if (((ord({ROT_A, ROT_B}) - ord(dec_prev) + 4) % 4) == 1) dec_sub = dec_sub + 1;
         else dec_sub = dec_sub - 1;
         if ({ROT_A, ROT_B} == 2'b00) begin
            if (dec_sub == 4)  dec_q.push_back(1'b1);
            if (dec_sub == -4) dec_q.push_back(1'b0);
            dec_sub = 0;
         end
         dec_prev = {ROT_A, ROT_B};
      end
   end

   // ---------------- driver tasks ----------------
   // Call sites are always 1 time unit after a rising edge.
   task automatic idle(input int m);
      repeat (m) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Issue one command and check every cycle from the accept edge to the done pulse.
   // The task returns in the cycle where done is high. A following call is therefore back-to-back.
   task automatic run_cmd(input logic dir, input int n);
      int               t_end, edges, pos0;
      logic [1:0]       prev, cur, e_ab;
      logic [POS_W-1:0] e_pos;
      t_end = (n == 0) ? 0 : n * 4 * P + (n - 1) * G;
      pos0  = exp_pos;
      vectors++;
      if (cmd_bus.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_before_accept: got %b want 1", cmd_bus.cmd_ready);
      end
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_dir   = dir;
      cmd_bus.cmd_steps = STEP_W'(n);
      prev  = {ROT_A, ROT_B};
      edges = 0;
      @(posedge CLK);
      #1;
      // Scramble the inputs after acceptance. The DUT must have latched them already.
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_dir   = 1'($urandom_range(0, 1));
      cmd_bus.cmd_steps = STEP_W'($urandom);
      for (int k = 0; k <= t_end + 1; k++) begin
         if (k > 0) begin
            @(posedge CLK);
            #1;
         end
         cur  = {ROT_A, ROT_B};
         e_ab = model_ab(dir, n, k);
         vectors++;
         if (cur !== e_ab) begin
            miscompares++;
            $display("FAIL ab k=%0d dir=%0d n=%0d: got %b want %b", k, dir, n, cur, e_ab);
         end
         if (cur !== prev) begin
            edges++;
            vectors++;
            if ((cur ^ prev) == 2'b11) begin
               miscompares++;
               $display("FAIL single_bit k=%0d: %b -> %b", k, prev, cur);
            end
         end
         e_pos = POS_W'(pos0 + (dir ? 1 : -1) * model_detents(n, k));
         vectors++;
         if (position !== e_pos) begin
            miscompares++;
            $display("FAIL position k=%0d: got %h want %h", k, position, e_pos);
         end
         vectors++;
         if (done !== (k == t_end + 1)) begin
            miscompares++;
            $display("FAIL done k=%0d n=%0d: got %b want %b", k, n, done, (k == t_end + 1));
         end
         vectors++;
         if (busy !== (n > 0 && k <= t_end)) begin
            miscompares++;
            $display("FAIL busy k=%0d n=%0d: got %b want %b", k, n, busy, (n > 0 && k <= t_end));
         end
         prev = cur;
      end
      vectors++;
      if (edges != 4 * n) begin
         miscompares++;
         $display("FAIL edge_count n=%0d: got %0d want %0d", n, edges, 4 * n);
      end
      exp_pos = pos0 + (dir ? n : -n);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RST = 1'b1;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_dir   = 1'b0;
      cmd_bus.cmd_steps = '0;
      repeat (3) @(posedge CLK);
      #1;
      vectors++;
      if ({ROT_A, ROT_B, cmd_bus.cmd_ready, busy, done} !== 5'b00100 || position !== '0) begin
         miscompares++;
         $display("FAIL reset_state: ab=%b%b ready=%b busy=%b done=%b pos=%h want 00 1 0 0 0000",
                  ROT_A, ROT_B, cmd_bus.cmd_ready, busy, done, position);
      end
      @(negedge CLK);
      RST = 1'b0;
      exp_pos = 0;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_right_one();
      run_cmd(1'b1, 1);
   endtask

   task automatic test_left_three();
      idle(2);
      run_cmd(1'b0, 3);
   endtask

   task automatic test_zero_steps();
      idle(1);
      run_cmd(1'($urandom_range(0, 1)), 0);
   endtask

   task automatic test_back_to_back();
      idle(1);
      run_cmd(1'b1, 2);
      run_cmd(1'b0, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         idle($urandom_range(0, 2));
         run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 5));
      end
   endtask

   task automatic test_max_steps();
      idle(1);
      run_cmd(1'b1, (1 << STEP_W) - 1);
   endtask

   task automatic test_reset_mid();
      if (POS_W'(exp_pos) == '0) run_cmd(1'b1, 1);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_dir   = 1'b1;
      cmd_bus.cmd_steps = STEP_W'(1);
      @(posedge CLK);
      #1;
      cmd_bus.cmd_valid = 1'b0;
      idle(2 * P + 1);
      vectors++;
      if ({ROT_A, ROT_B} !== 2'b11) begin
         miscompares++;
         $display("FAIL pre_reset_ab: got %b%b want 11", ROT_A, ROT_B);
      end
      #1 RST = 1'b1;
      #1;
      vectors++;
      if ({ROT_A, ROT_B} !== 2'b00 || position !== '0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: ab=%b%b pos=%h busy=%b want 00 0000 0",
                  ROT_A, ROT_B, position, busy);
      end
      @(negedge CLK);
      RST = 1'b0;
      exp_pos = 0;
      @(posedge CLK);
      #1;
      vectors++;
      if (cmd_bus.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_reset: got %b want 1", cmd_bus.cmd_ready);
      end
      run_cmd(1'b1, 1);
   endtask

   task automatic test_loopback();
      int start;
      idle(1);
      start = exp_pos;
      dec_q.delete();
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back(1'b1);
      for (int i = 0; i < 5; i++)  exp_q.push_back(1'b0);
      run_cmd(1'b1, 20);
      run_cmd(1'b0, 5);
      idle(2);
      vectors++;
      if (dec_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL loopback_count: got %0d want %0d", dec_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++) begin
         vectors++;
         if (dec_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL loopback_event %0d: got %b want %b", i, dec_q[i], exp_q[i]);
         end
      end
      vectors++;
      if (position !== POS_W'(start + 15)) begin
         miscompares++;
         $display("FAIL loopback_position: got %h want %h", position, POS_W'(start + 15));
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_right_one();
      test_left_three();
      test_zero_steps();
      test_back_to_back();
      test_random();
      test_max_steps();
      test_reset_mid();
      test_loopback();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      miscompares++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
